// File: rtl/mem_capture_master_pkg.sv
// rtl/mem_capture_master_pkg.sv - shared types and defaults for the memory master family
// Contents: FSM state enum, default widths, RAM depth derivation.
package mem_master_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DELAY_W = 8;
    localparam int DEF_COORD_W = 13;

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        POST,
        DONE
    } state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/mem_capture_master_if.sv
// rtl/mem_capture_master_if.sv - Avalon-MM write bus between capture master and sample RAM
// Signals: av_cs, av_write (master -> slave, identical), av_addr (master -> slave),
//          av_waitrequest (slave -> master back-pressure).
interface mem_capture_master_if
    import mem_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              av_cs;
    logic              av_write;
    logic [ADDR_W-1:0] av_addr;
    logic              av_waitrequest;

    modport master (
        output av_cs,
        output av_write,
        output av_addr,
        input  av_waitrequest
    );

    modport slave (
        input  av_cs,
        input  av_write,
        input  av_addr,
        output av_waitrequest
    );
endinterface

// File: rtl/mem_capture_master_post_delay_cnt.sv
// rtl/mem_capture_master_post_delay_cnt.sv - loadable down counter for post-trigger writes
// Ports: clk, rst (async, active-high), load/load_val, en (decrement),
//        zero (count is 0), last (count is 1, next enabled decrement reaches 0).
module post_delay_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero,
    output logic             last
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == WIDTH'(1));
endmodule

// File: rtl/mem_capture_master.sv
// rtl/mem_capture_master.sv - circular-RAM capture write master with trigger latch and re-arm
// Ports: ref_clk, reset (async, active-high); start, stop, stop_delay, coarse_counter, ack;
//        av (Avalon write master); status wr_ptr, trig_addr, sample_size, pulse_abs_coord,
//        stop_detected, wrapped, overrun, done.
module mem_capture_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DELAY_W = DEF_DELAY_W,
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic                 ref_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [DELAY_W-1:0]   stop_delay,
    input  logic [COORD_W-1:0]   coarse_counter,
    input  logic                 ack,
    mem_capture_master_if.master av,
    output logic [ADDR_W-1:0]    wr_ptr,
    output logic [ADDR_W-1:0]    trig_addr,
    output logic [ADDR_W:0]      sample_size,
    output logic [COORD_W-1:0]   pulse_abs_coord,
    output logic                 stop_detected,
    output logic                 wrapped,
    output logic                 overrun,
    output logic                 done
);
    localparam int              DEPTH     = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] SIZE_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t state_q, state_d;
    logic   write_en;
    logic   accept;
    logic   post_zero;
    logic   post_last;

    assign write_en    = (state_q == RECORD) || (state_q == POST);
    assign accept      = write_en && !av.av_waitrequest;
    assign done        = (state_q == DONE);
    assign av.av_cs    = write_en;
    assign av.av_write = write_en;
    assign av.av_addr  = wr_ptr;

    // Loaded on the trigger cycle; counts accepted POST writes down to zero.
    post_delay_cnt #(.WIDTH(DELAY_W)) u_post_cnt (
        .clk      (ref_clk),
        .rst      (reset),
        .load     ((state_q == RECORD) && stop),
        .load_val (stop_delay),
        .en       ((state_q == POST) && accept),
        .zero     (post_zero),
        .last     (post_last)
    );

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RECORD;
            RECORD:  if (stop) state_d = (stop_delay == '0) ? DONE : POST;
            // post_zero only guards against a counter that never got loaded.
            POST:    if ((accept && post_last) || post_zero) state_d = DONE;
            DONE:    if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            wr_ptr          <= '0;
            trig_addr       <= '0;
            sample_size     <= '0;
            pulse_abs_coord <= '0;
            stop_detected   <= 1'b0;
            wrapped         <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        wr_ptr        <= '0;
                        sample_size   <= '0;
                        wrapped       <= 1'b0;
                        stop_detected <= 1'b0;
                    end
                end
                RECORD: begin
                    // sample_size covers start..trigger inclusive, so only RECORD accepts count.
                    if (accept && (sample_size != SIZE_MAX)) begin
                        sample_size <= sample_size + 1'b1;
                    end
                    if (stop) begin
                        trig_addr       <= wr_ptr;
                        pulse_abs_coord <= coarse_counter;
                        stop_detected   <= 1'b1;
                    end
                end
                POST, DONE: begin
                    if (stop) overrun <= 1'b1;
                end
                default: ;
            endcase

            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == LAST_ADDR) wrapped <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_capture_master.sv
// tb/tb_mem_capture_master.sv - self-checking bench for mem_capture_master
module tb_mem_capture_master;
    localparam int DEPTH = 256;

    logic        ref_clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [7:0]  stop_delay;
    logic [12:0] coarse_counter;
    logic        ack;
    logic [7:0]  wr_ptr;
    logic [7:0]  trig_addr;
    logic [8:0]  sample_size;
    logic [12:0] pulse_abs_coord;
    logic        stop_detected;
    logic        wrapped;
    logic        overrun;
    logic        done;

    int checks = 0;
    int passed = 0;
    bit exp_overrun = 0;

    mem_capture_master_if #(.ADDR_W(8)) av_bus ();

    mem_capture_master #(.ADDR_W(8), .DELAY_W(8), .COORD_W(13)) dut (
        .ref_clk         (ref_clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .stop_delay      (stop_delay),
        .coarse_counter  (coarse_counter),
        .ack             (ack),
        .av              (av_bus),
        .wr_ptr          (wr_ptr),
        .trig_addr       (trig_addr),
        .sample_size     (sample_size),
        .pulse_abs_coord (pulse_abs_coord),
        .stop_detected   (stop_detected),
        .wrapped         (wrapped),
        .overrun         (overrun),
        .done            (done)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive inputs for the next rising edge; coarse time is a fresh random value each cycle.
    task automatic drive(input bit s, input bit p, input bit w, input bit a);
        start                 = s;
        stop                  = p;
        av_bus.av_waitrequest = w;
        ack                   = a;
        coarse_counter        = 13'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cs"},       av_bus.av_cs, 0);
        check({tag, "_write"},    av_bus.av_write, 0);
        check({tag, "_addr"},     av_bus.av_addr, 0);
        check({tag, "_wr_ptr"},   wr_ptr, 0);
        check({tag, "_trig"},     trig_addr, 0);
        check({tag, "_size"},     sample_size, 0);
        check({tag, "_coord"},    pulse_abs_coord, 0);
        check({tag, "_stopdet"},  stop_detected, 0);
        check({tag, "_wrapped"},  wrapped, 0);
        check({tag, "_overrun"},  overrun, 0);
        check({tag, "_done"},     done, 0);
    endtask

    // One full capture run. Reference: every cycle the master writes, a low
    // waitrequest is one accepted word at address (accepts so far) mod DEPTH.
    task automatic run(input int pre, input int dly, input int pct, input bit ss, input bit stop_done);
        int          acc;
        int          pre_acc;
        int          trig_acc;
        int          post_acc;
        int          exp_size;
        bit          w;
        bit          finished;
        logic [12:0] coord;

        @(negedge ref_clk);
        check("idle_write", av_bus.av_write, 0);
        check("idle_done", done, 0);
        stop_delay = 8'(dly);
        drive(1'b1, ss, 1'b0, 1'b0);
        acc = 0;

        for (int i = 0; i < pre; i++) begin
            @(negedge ref_clk);
            check("rec_write", av_bus.av_write, 1);
            check("rec_cs", av_bus.av_cs, 1);
            check("rec_addr", av_bus.av_addr, acc % DEPTH);
            check("rec_stopdet", stop_detected, 0);
            w = ($urandom_range(99) < pct);
            drive(1'b0, 1'b0, w, 1'b0);
            if (!w) acc++;
        end

        @(negedge ref_clk);
        check("trig_cyc_write", av_bus.av_write, 1);
        check("trig_cyc_addr", av_bus.av_addr, acc % DEPTH);
        w = ($urandom_range(99) < pct);
        drive(1'b0, 1'b1, w, 1'b0);
        coord    = coarse_counter;
        pre_acc  = acc;
        trig_acc = w ? 0 : 1;
        acc      = acc + trig_acc;

        post_acc = 0;
        finished = 0;
        for (int g = 0; g < 2000; g++) begin
            @(negedge ref_clk);
            if (post_acc == dly) begin
                check("done_on_time", done, 1);
                check("done_write_off", av_bus.av_write, 0);
                finished = 1;
                break;
            end
            check("post_not_done", done, 0);
            check("post_write", av_bus.av_write, 1);
            check("post_addr", av_bus.av_addr, acc % DEPTH);
            w = ($urandom_range(99) < pct);
            drive(1'b0, 1'b0, w, 1'b0);
            if (!w) begin
                acc++;
                post_acc++;
            end
        end
        if (!finished) check("post_timeout", 0, 1);

        exp_size = (pre_acc + trig_acc > DEPTH) ? DEPTH : pre_acc + trig_acc;
        check("trig_addr", trig_addr, pre_acc % DEPTH);
        check("sample_size", sample_size, exp_size);
        check("pulse_coord", pulse_abs_coord, coord);
        check("stop_detected", stop_detected, 1);
        check("final_wr_ptr", wr_ptr, acc % DEPTH);
        check("wrapped", wrapped, (acc >= DEPTH) ? 1 : 0);
        check("overrun", overrun, exp_overrun);

        if (stop_done) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            exp_overrun = 1;
            @(negedge ref_clk);
            check("ovr_set", overrun, 1);
            check("ovr_done_held", done, 1);
            check("ovr_wr_ptr", wr_ptr, acc % DEPTH);
            check("ovr_trig", trig_addr, pre_acc % DEPTH);
            check("ovr_size", sample_size, exp_size);
            check("ovr_coord", pulse_abs_coord, coord);
        end

        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge ref_clk);
        check("ack_done_clr", done, 0);
        check("ack_write_off", av_bus.av_write, 0);
        check("ack_overrun_kept", overrun, exp_overrun);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        stop_delay = 8'd0;
        #1;
        check_all_zero("reset");
        @(negedge ref_clk);
        reset = 1'b0;

        run(10, 5, 0, 1'b0, 1'b0);
        run(300, 3, 0, 1'b0, 1'b0);
        run(10, 4, 50, 1'b0, 1'b0);
        run(20, 0, 0, 1'b0, 1'b1);
        run(5, 3, 0, 1'b1, 1'b0);
        for (int r = 0; r < 5; r++) begin
            run(int'($urandom_range(400)), int'($urandom_range(20)), 30, 1'b0, $urandom_range(1) == 1);
        end

        // Asynchronous reset in the middle of POST, between clock edges.
        stop_delay = 8'd50;
        @(negedge ref_clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge ref_clk);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge ref_clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge ref_clk);
            drive(1'b0, 1'b0, 1'b1, 1'b0);
        end
        @(negedge ref_clk);
        check("pre_reset_write", av_bus.av_write, 1);
        check("pre_reset_overrun", overrun, exp_overrun);
        #2 reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge ref_clk);
        reset       = 1'b0;
        exp_overrun = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        run(7, 2, 20, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
